// File: rtl/counter_modn_updown_if.sv
// Control and status bundle for counter_modn_updown: the master drives the controls
// and the counter, on the slave side, returns its value and its pulses.
interface counter_modn_updown_if #(
  parameter int WIDTH = 3
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up_dn;
  logic [WIDTH-1:0] dout;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (
    output clr, load, load_val, en, up_dn,
    input  dout, tc, wrap, load_err
  );

  modport slave (
    input  clr, load, load_val, en, up_dn,
    output dout, tc, wrap, load_err
  );
endinterface

// File: rtl/counter_modn_updown.sv
// Modulo-MOD up/down counter with clear, range-checked load, combinational terminal
// count for cascading, and registered wrap / load-error pulses.
module counter_modn_updown #(
  parameter int WIDTH = 3,
  parameter int MOD   = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  counter_modn_updown_if.slave  bus
);

  generate
    if (MOD < 2 || MOD > (2 ** WIDTH)) begin : g_bad_mod
      $error("counter_modn_updown: MOD=%0d is outside 2..2**WIDTH (WIDTH=%0d)", MOD, WIDTH);
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic             at_max, at_zero, load_oob;

  assign at_max   = (dout_q == MAX_VAL);
  assign at_zero  = (dout_q == '0);
  assign load_oob = (32'(bus.load_val) >= 32'(MOD));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q     <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  // Priority: clr > load > en > hold. Pulses default low so they last one cycle.
  always_comb begin
    dout_d     = dout_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (bus.clr) begin
      dout_d = '0;
    end else if (bus.load) begin
      if (load_oob) begin
        dout_d     = MAX_VAL;
        load_err_d = 1'b1;
      end else begin
        dout_d = bus.load_val;
      end
    end else if (bus.en) begin
      if (bus.up_dn) begin
        dout_d = at_max ? '0 : dout_q + ONE;
        wrap_d = at_max;
      end else begin
        dout_d = at_zero ? MAX_VAL : dout_q - ONE;
        wrap_d = at_zero;
      end
    end
  end

  // tc deliberately ignores clr/load so a cascaded stage sees a pure count carry.
  assign bus.tc       = bus.en & ((bus.up_dn & at_max) | (~bus.up_dn & at_zero));
  assign bus.dout     = dout_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_counter_modn_updown.sv
// Directed bench for counter_modn_updown: mod-6 single instance plus a mod-10/mod-6 cascade.
module tb_counter_modn_updown;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  counter_modn_updown_if #(.WIDTH(3)) m_if ();
  counter_modn_updown_if #(.WIDTH(4)) lo_if ();
  counter_modn_updown_if #(.WIDTH(3)) hi_if ();

  counter_modn_updown #(.WIDTH(3), .MOD(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (m_if.slave)
  );

  counter_modn_updown #(.WIDTH(4), .MOD(10)) u_lo (
    .clk   (clk),
    .reset (reset),
    .bus   (lo_if.slave)
  );

  counter_modn_updown #(.WIDTH(3), .MOD(6)) u_hi (
    .clk   (clk),
    .reset (reset),
    .bus   (hi_if.slave)
  );

  assign hi_if.en = lo_if.tc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks += 3;
    if (m_if.dout !== 3'd0) begin failures++; $display("FAIL reset_dout got=%0d exp=0", m_if.dout); end
    if (m_if.wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", m_if.wrap); end
    if (m_if.load_err !== 1'b0) begin failures++; $display("FAIL reset_load_err got=%b exp=0", m_if.load_err); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (m_if.dout !== 3'd0) begin failures++; $display("FAIL reset_hold got=%0d exp=0", m_if.dout); end
  endtask

  task automatic test_count_up();
    logic [2:0] exp_d [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    m_if.en = 1'b1;
    m_if.up_dn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks += 3;
      if (m_if.dout !== exp_d[i]) begin failures++; $display("FAIL up_dout[%0d] got=%0d exp=%0d", i, m_if.dout, exp_d[i]); end
      if (m_if.wrap !== (exp_d[i] == 3'd0)) begin failures++; $display("FAIL up_wrap[%0d] got=%b exp=%b", i, m_if.wrap, exp_d[i] == 3'd0); end
      if (m_if.tc !== (exp_d[i] == 3'd5)) begin failures++; $display("FAIL up_tc[%0d] got=%b exp=%b", i, m_if.tc, exp_d[i] == 3'd5); end
    end
  endtask

  task automatic test_count_down();
    logic [2:0] exp_d [3] = '{3'd5, 3'd4, 3'd3};
    m_if.en = 1'b0;
    m_if.clr = 1'b1;
    tick();
    m_if.clr = 1'b0;
    m_if.en = 1'b1;
    m_if.up_dn = 1'b0;
    #1;
    checks += 2;
    if (m_if.dout !== 3'd0) begin failures++; $display("FAIL down_start got=%0d exp=0", m_if.dout); end
    if (m_if.tc !== 1'b1) begin failures++; $display("FAIL down_tc_at0 got=%b exp=1", m_if.tc); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks += 3;
      if (m_if.dout !== exp_d[i]) begin failures++; $display("FAIL down_dout[%0d] got=%0d exp=%0d", i, m_if.dout, exp_d[i]); end
      if (m_if.wrap !== (i == 0)) begin failures++; $display("FAIL down_wrap[%0d] got=%b exp=%b", i, m_if.wrap, i == 0); end
      if (m_if.tc !== 1'b0) begin failures++; $display("FAIL down_tc[%0d] got=%b exp=0", i, m_if.tc); end
    end
  endtask

  task automatic test_direction_change();
    logic       dir   [3] = '{1'b1, 1'b0, 1'b1};
    logic [2:0] exp_d [3] = '{3'd4, 3'd3, 3'd4};
    m_if.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_if.up_dn = dir[i];
      tick();
      checks++;
      if (m_if.dout !== exp_d[i]) begin failures++; $display("FAIL dir_dout[%0d] got=%0d exp=%0d", i, m_if.dout, exp_d[i]); end
    end
  endtask

  task automatic test_load();
    m_if.en = 1'b0;
    m_if.load = 1'b1;
    m_if.load_val = 3'd7;
    tick();
    checks += 2;
    if (m_if.dout !== 3'd5) begin failures++; $display("FAIL load7_dout got=%0d exp=5", m_if.dout); end
    if (m_if.load_err !== 1'b1) begin failures++; $display("FAIL load7_err got=%b exp=1", m_if.load_err); end
    m_if.load_val = 3'd2;
    tick();
    checks += 2;
    if (m_if.dout !== 3'd2) begin failures++; $display("FAIL load2_dout got=%0d exp=2", m_if.dout); end
    if (m_if.load_err !== 1'b0) begin failures++; $display("FAIL load2_err got=%b exp=0", m_if.load_err); end
    m_if.load_val = 3'd6;
    tick();
    checks += 2;
    if (m_if.dout !== 3'd5) begin failures++; $display("FAIL load6_dout got=%0d exp=5", m_if.dout); end
    if (m_if.load_err !== 1'b1) begin failures++; $display("FAIL load6_err got=%b exp=1", m_if.load_err); end
    m_if.load = 1'b0;
    tick();
    checks += 2;
    if (m_if.dout !== 3'd5) begin failures++; $display("FAIL load_hold_dout got=%0d exp=5", m_if.dout); end
    if (m_if.load_err !== 1'b0) begin failures++; $display("FAIL load_err_pulse got=%b exp=0", m_if.load_err); end
    m_if.en = 1'b1;
    m_if.up_dn = 1'b1;
    m_if.load = 1'b1;
    m_if.load_val = 3'd0;
    #1;
    checks++;
    if (m_if.tc !== 1'b1) begin failures++; $display("FAIL tc_ignores_load got=%b exp=1", m_if.tc); end
    tick();
    checks += 2;
    if (m_if.dout !== 3'd0) begin failures++; $display("FAIL load0_dout got=%0d exp=0", m_if.dout); end
    if (m_if.wrap !== 1'b0) begin failures++; $display("FAIL load_no_wrap got=%b exp=0", m_if.wrap); end
    m_if.load = 1'b0;
    m_if.en = 1'b0;
  endtask

  task automatic test_clr_priority();
    m_if.load = 1'b1;
    m_if.load_val = 3'd4;
    tick();
    checks++;
    if (m_if.dout !== 3'd4) begin failures++; $display("FAIL clr_setup got=%0d exp=4", m_if.dout); end
    m_if.clr = 1'b1;
    m_if.load_val = 3'd7;
    m_if.en = 1'b1;
    m_if.up_dn = 1'b1;
    tick();
    checks += 3;
    if (m_if.dout !== 3'd0) begin failures++; $display("FAIL clr_dout got=%0d exp=0", m_if.dout); end
    if (m_if.wrap !== 1'b0) begin failures++; $display("FAIL clr_wrap got=%b exp=0", m_if.wrap); end
    if (m_if.load_err !== 1'b0) begin failures++; $display("FAIL clr_load_err got=%b exp=0", m_if.load_err); end
    m_if.clr = 1'b0;
    m_if.load = 1'b0;
    m_if.en = 1'b0;
  endtask

  task automatic test_async_reset();
    m_if.load = 1'b1;
    m_if.load_val = 3'd3;
    tick();
    m_if.load = 1'b0;
    checks++;
    if (m_if.dout !== 3'd3) begin failures++; $display("FAIL arst_setup got=%0d exp=3", m_if.dout); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (m_if.dout !== 3'd0) begin failures++; $display("FAIL arst_immediate got=%0d exp=0", m_if.dout); end
    @(negedge clk);
    reset = 1'b0;
    m_if.en = 1'b1;
    m_if.up_dn = 1'b1;
    tick();
    checks++;
    if (m_if.dout !== 3'd1) begin failures++; $display("FAIL arst_resume got=%0d exp=1", m_if.dout); end
    m_if.en = 1'b0;
  endtask

  task automatic test_cascade();
    int hi_wraps = 0;
    int hi_zero_entries = 0;
    int wrap_clk = -1;
    logic [2:0] hi_prev;
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    lo_if.en = 1'b1;
    hi_prev = hi_if.dout;
    for (int c = 1; c <= 60; c++) begin
      tick();
      checks += 2;
      if (lo_if.dout !== 4'(c % 10)) begin failures++; $display("FAIL casc_lo[%0d] got=%0d exp=%0d", c, lo_if.dout, c % 10); end
      if (hi_if.dout !== 3'((c / 10) % 6)) begin failures++; $display("FAIL casc_hi[%0d] got=%0d exp=%0d", c, hi_if.dout, (c / 10) % 6); end
      if (hi_if.wrap === 1'b1) begin hi_wraps++; wrap_clk = c; end
      if (hi_if.dout == 3'd0 && hi_prev != 3'd0) hi_zero_entries++;
      hi_prev = hi_if.dout;
    end
    lo_if.en = 1'b0;
    checks += 3;
    if (hi_wraps !== 1) begin failures++; $display("FAIL casc_wrap_count got=%0d exp=1", hi_wraps); end
    if (wrap_clk !== 60) begin failures++; $display("FAIL casc_wrap_clk got=%0d exp=60", wrap_clk); end
    if (hi_zero_entries !== 1) begin failures++; $display("FAIL casc_hi_to_zero got=%0d exp=1", hi_zero_entries); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_if.clr = 1'b0;  m_if.load = 1'b0;  m_if.load_val = '0;  m_if.en = 1'b0;  m_if.up_dn = 1'b1;
    lo_if.clr = 1'b0; lo_if.load = 1'b0; lo_if.load_val = '0; lo_if.en = 1'b0; lo_if.up_dn = 1'b1;
    hi_if.clr = 1'b0; hi_if.load = 1'b0; hi_if.load_val = '0; hi_if.up_dn = 1'b1;
    test_reset();
    test_count_up();
    test_count_down();
    test_direction_change();
    test_load();
    test_clr_priority();
    test_async_reset();
    test_cascade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout reached without completing");
    $fatal(1, "timeout");
  end

endmodule
